// File: rtl/memwb_pkg.sv
// Shared constants for the memory/writeback stage: instruction-class codes,
// load/store funct3 codes and small decode helpers.
package memwb_pkg;

    localparam logic [4:0] RTYPE = 5'd1;
    localparam logic [4:0] ITYPE = 5'd2;
    localparam logic [4:0] STYPE = 5'd3;
    localparam logic [4:0] BTYPE = 5'd4;
    localparam logic [4:0] UTYPE = 5'd5;
    localparam logic [4:0] LTYPE = 5'd6;

    localparam logic [2:0] LB3  = 3'b000;
    localparam logic [2:0] LH3  = 3'b001;
    localparam logic [2:0] LW3  = 3'b010;
    localparam logic [2:0] LBU3 = 3'b100;
    localparam logic [2:0] LHU3 = 3'b101;
    localparam logic [2:0] SB3  = 3'b000;
    localparam logic [2:0] SH3  = 3'b001;
    localparam logic [2:0] SW3  = 3'b010;

    function automatic logic load_f3_ok(input logic [2:0] f3);
        return (f3 == LB3) || (f3 == LH3) || (f3 == LW3) || (f3 == LBU3) || (f3 == LHU3);
    endfunction

    function automatic logic store_f3_ok(input logic [2:0] f3);
        return (f3 == SB3) || (f3 == SH3) || (f3 == SW3);
    endfunction

    // Store funct3 codes share the load encodings for size, so one check serves both.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic r;
        r = 1'b0;
        if (f3 == LH3 || f3 == LHU3)
            r = off[0];
        else if (f3 == LW3)
            r = (off != 2'b00);
        return r;
    endfunction

endpackage

// File: rtl/memwb_load_align.sv
// Load data alignment: selects the addressed byte/halfword of a read word and
// sign- or zero-extends it according to funct3.
module load_align
    import memwb_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (off)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];

        value = rdata;
        case (funct3)
            LB3:     value = {{24{byte_sel[7]}}, byte_sel};
            LBU3:    value = {24'h000000, byte_sel};
            LH3:     value = {{16{half_sel[15]}}, half_sel};
            LHU3:    value = {16'h0000, half_sel};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/memwb.sv
// Memory access and register writeback stage: captures one instruction on
// stage 4, performs an optional load/store handshake, then writes back.
module memwb
    import memwb_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  stage_i,
    input  logic [31:0] ir_i,
    input  logic [4:0]  itype_i,
    input  logic [31:0] y_i,
    input  logic [31:0] pass_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        busy_o,
    output logic        fault_o
);

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_WB, S_DONE} state_t;

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t          state, state_nx;
    logic [4:0]      rd_q;
    logic [2:0]      f3_q;
    logic [4:0]      itype_q;
    logic [31:0]     y_q;
    logic [31:0]     pass_q;
    logic [31:0]     wb_q;
    logic [CNT_W-1:0] cnt_q;

    logic            capture;
    logic            set_fault;
    logic [2:0]      f3_i;
    logic            f3_ok_i;
    logic            misal_i;
    logic            is_store_q;
    logic            in_mem;
    logic [31:0]     ld_value;

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] s;
        case (f3)
            SB3:     s = 4'b0001 << off;
            SH3:     s = 4'b0011 << off;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3)
            SB3:     w = {4{d[7:0]}};
            SH3:     w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    assign f3_i    = ir_i[14:12];
    assign f3_ok_i = (itype_i == LTYPE) ? load_f3_ok(f3_i) : store_f3_ok(f3_i);
    assign misal_i = misaligned(f3_i, y_i[1:0]);

    always_comb begin
        state_nx  = state;
        capture   = 1'b0;
        set_fault = 1'b0;
        case (state)
            S_IDLE: begin
                if (stage_i == 3'd4) begin
                    capture = 1'b1;
                    case (itype_i)
                        LTYPE, STYPE: begin
                            if (!f3_ok_i) begin
                                state_nx = S_DONE;
                            end else if (misal_i) begin
                                set_fault = 1'b1;
                                state_nx  = S_DONE;
                            end else begin
                                state_nx = S_MEM;
                            end
                        end
                        RTYPE, ITYPE, UTYPE: state_nx = S_WB;
                        default:             state_nx = S_DONE;
                    endcase
                end
            end
            S_MEM: begin
                if (mem_ack_i) begin
                    state_nx = is_store_q ? S_DONE : S_WB;
                end else if (cnt_q == CNT_LAST) begin
                    set_fault = 1'b1;
                    state_nx  = S_DONE;
                end
            end
            S_WB:    state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            rd_q    <= '0;
            f3_q    <= '0;
            itype_q <= '0;
            y_q     <= '0;
            pass_q  <= '0;
            wb_q    <= '0;
            cnt_q   <= '0;
            fault_o <= 1'b0;
        end else begin
            state   <= state_nx;
            fault_o <= fault_o | set_fault;
            if (capture) begin
                rd_q    <= ir_i[11:7];
                f3_q    <= f3_i;
                itype_q <= itype_i;
                y_q     <= y_i;
                pass_q  <= pass_i;
                wb_q    <= (itype_i == UTYPE) ? {ir_i[31:12], 12'h000} : y_i;
                cnt_q   <= '0;
            end else if (state == S_MEM) begin
                cnt_q <= cnt_q + 1'b1;
                if (mem_ack_i && !is_store_q)
                    wb_q <= ld_value;
            end
        end
    end

    load_align u_load_align (
        .rdata  (mem_rdata_i),
        .off    (y_q[1:0]),
        .funct3 (f3_q),
        .value  (ld_value)
    );

    // Outputs decode straight from registered state so reset clears them at once.
    assign is_store_q  = (itype_q == STYPE);
    assign in_mem      = (state == S_MEM);
    assign mem_req_o   = in_mem;
    assign mem_we_o    = in_mem && is_store_q;
    assign mem_addr_o  = {y_q[31:2], 2'b00};
    assign mem_wdata_o = store_data(f3_q, pass_q);
    assign mem_wstrb_o = (in_mem && is_store_q) ? store_strb(f3_q, y_q[1:0]) : 4'b0000;
    assign rf_we_o     = (state == S_WB) && (rd_q != 5'd0);
    assign rf_waddr_o  = rd_q;
    assign rf_wdata_o  = wb_q;
    assign busy_o      = (state != S_IDLE);

endmodule

// File: tb/tb_memwb.sv
// Self-checking bench for memwb: a transaction-level model predicts every
// cycle's outputs, and literal expectations pin the model's key results.
module tb_memwb;
    import memwb_pkg::*;

    localparam int T = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  stage_i;
    logic [31:0] ir_i, y_i, pass_i, mem_rdata_i;
    logic [4:0]  itype_i;
    logic        mem_ack_i;
    logic        mem_req_o, mem_we_o, rf_we_o, busy_o, fault_o;
    logic [31:0] mem_addr_o, mem_wdata_o, rf_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic [4:0]  rf_waddr_o;

    always #5 clk = ~clk;

    memwb #(.ACK_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .stage_i(stage_i), .ir_i(ir_i), .itype_i(itype_i),
        .y_i(y_i), .pass_i(pass_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .rf_we_o(rf_we_o),
        .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .busy_o(busy_o), .fault_o(fault_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected per-cycle outputs, set by the driver, compared on the falling edge.
    bit          chk_en = 1'b0;
    logic        e_busy = 0, e_req = 0, e_we = 0, e_rf_we = 0, e_fault = 0;
    logic [31:0] e_addr = 0, e_wd = 0, e_rfwd = 0;
    logic [3:0]  e_strb = 0;
    logic [4:0]  e_waddr = 0;

    int          n_req = 0, n_rf = 0;
    logic [31:0] last_addr = 0, last_wdata = 0, last_rfwd = 0;
    logic [3:0]  last_strb = 0;
    logic [4:0]  last_waddr = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy_o, e_busy);
            chk("fault", fault_o, e_fault);
            chk("mem_req", mem_req_o, e_req);
            chk("mem_we", mem_we_o, e_we);
            chk("mem_wstrb", mem_wstrb_o, e_strb);
            chk("rf_we", rf_we_o, e_rf_we);
            if (e_req) chk("mem_addr", mem_addr_o, e_addr);
            if (e_we) chk("mem_wdata", mem_wdata_o, e_wd);
            if (e_rf_we) begin
                chk("rf_waddr", rf_waddr_o, e_waddr);
                chk("rf_wdata", rf_wdata_o, e_rfwd);
            end
        end
        if (mem_req_o) begin
            n_req++;
            last_addr = mem_addr_o;
            last_wdata = mem_wdata_o;
            last_strb = mem_wstrb_o;
        end
        if (rf_we_o) begin
            n_rf++;
            last_rfwd = rf_wdata_o;
            last_waddr = rf_waddr_o;
        end
    end

    task automatic set_idle();
        e_busy = 0; e_req = 0; e_we = 0; e_strb = 0; e_rf_we = 0;
    endtask

    // kind: 0 = nothing to do, 1 = plain writeback, 2 = load, 3 = store
    function automatic void model(input logic [31:0] ir, input logic [4:0] it,
                                  input logic [31:0] y, input logic [31:0] pass,
                                  input logic [31:0] rdata, output int kind, output bit misal,
                                  output logic [31:0] wbv, output logic [3:0] strb,
                                  output logic [31:0] wd);
        int f3, off, size;
        logic [31:0] sh;
        f3 = int'(ir[14:12]);
        off = int'(y % 4);
        kind = 0; misal = 0; wbv = 0; strb = 0; wd = 0; size = 0;
        sh = rdata >> (8 * off);
        if (it == RTYPE || it == ITYPE) begin
            kind = 1; wbv = y;
        end else if (it == UTYPE) begin
            kind = 1; wbv = ir & 32'hFFFF_F000;
        end else if (it == LTYPE) begin
            if (f3 == 0 || f3 == 4) size = 1;
            else if (f3 == 1 || f3 == 5) size = 2;
            else if (f3 == 2) size = 4;
            if (size != 0) begin
                kind = 2;
                misal = (y % size) != 0;
                case (f3)
                    0: begin wbv = sh & 32'hFF;   if (wbv >= 128)   wbv = wbv - 256; end
                    4: wbv = sh & 32'hFF;
                    1: begin wbv = sh & 32'hFFFF; if (wbv >= 32768) wbv = wbv - 65536; end
                    5: wbv = sh & 32'hFFFF;
                    default: wbv = rdata;
                endcase
            end
        end else if (it == STYPE) begin
            if (f3 == 0) begin size = 1; wd = (pass & 32'hFF) * 32'h0101_0101; end
            else if (f3 == 1) begin size = 2; wd = (pass & 32'hFFFF) * 32'h0001_0001; end
            else if (f3 == 2) begin size = 4; wd = pass; end
            if (size != 0) begin
                kind = 3;
                misal = (y % size) != 0;
                strb = 4'(((1 << size) - 1) << off);
            end
        end
    endfunction

    function automatic logic [31:0] mk(input int rd, input int f3);
        return (f3 << 12) | (rd << 7);
    endfunction

    // ack_at: MEM cycle index (0 = first) carrying the ack; -1 never acks.
    task automatic run(input logic [31:0] ir, input logic [4:0] it, input logic [31:0] y,
                       input logic [31:0] pass, input logic [31:0] rdata,
                       input int ack_at, input bit hold);
        int kind;
        bit misal, acked;
        logic [31:0] wbv, wd;
        logic [3:0] strb;
        model(ir, it, y, pass, rdata, kind, misal, wbv, strb, wd);
        n_req = 0; n_rf = 0; acked = 0;
        @(posedge clk); #1;
        stage_i = 3'd4; ir_i = ir; itype_i = it; y_i = y; pass_i = pass;
        set_idle();
        @(posedge clk); #1;
        if (!hold) stage_i = 3'd0;
        ir_i = 32'hFFFF_FFFF; itype_i = RTYPE; y_i = 32'hDEAD_BEEF; pass_i = 32'h5A5A_5A5A;
        if ((kind == 2 || kind == 3) && !misal) begin
            for (int k = 0; k < T; k++) begin
                e_busy = 1; e_req = 1; e_we = (kind == 3); e_addr = y & ~32'h3;
                e_wd = wd; e_strb = (kind == 3) ? strb : 4'b0000; e_rf_we = 0;
                if (k == ack_at) begin mem_ack_i = 1; mem_rdata_i = rdata; end
                @(posedge clk); #1;
                mem_ack_i = 0; mem_rdata_i = 32'h0;
                if (k == ack_at) begin acked = 1; break; end
            end
            if (!acked) e_fault = 1;
        end else if (misal) begin
            e_fault = 1;
        end
        if (kind == 1 || (kind == 2 && acked && !misal)) begin
            e_busy = 1; e_req = 0; e_we = 0; e_strb = 0;
            e_rf_we = (ir[11:7] != 5'd0); e_waddr = ir[11:7]; e_rfwd = wbv;
            @(posedge clk); #1;
        end
        e_busy = 1; e_req = 0; e_we = 0; e_strb = 0; e_rf_we = 0;
        @(posedge clk); #1;
        stage_i = 3'd0;
        set_idle();
    endtask

    initial begin
        reset = 0; stage_i = 0; ir_i = 0; itype_i = 0; y_i = 0; pass_i = 0;
        mem_ack_i = 0; mem_rdata_i = 0;
        repeat (2) @(posedge clk); #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_req", mem_req_o, 0);
        chk("rst_we", mem_we_o, 0);
        chk("rst_wstrb", mem_wstrb_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_wdata", mem_wdata_o, 0);
        chk("rst_rf_we", rf_we_o, 0);
        chk("rst_rf_wdata", rf_wdata_o, 0);
        chk("rst_fault", fault_o, 0);
        @(negedge clk); reset = 1;
        set_idle(); chk_en = 1;

        run(mk(5, 0), RTYPE, 32'h1234, 0, 0, -1, 0);
        chk("rtype_rf_count", n_rf, 1); chk("rtype_req_count", n_req, 0);
        chk("rtype_waddr", last_waddr, 5); chk("rtype_wdata", last_rfwd, 32'h1234);

        run(mk(0, SB3), STYPE, 32'h1003, 32'hAB, 0, 2, 0);
        chk("sb_addr", last_addr, 32'h1000); chk("sb_strb", last_strb, 4'b1000);
        chk("sb_wdata", last_wdata, 32'hABAB_ABAB); chk("sb_rf_count", n_rf, 0);
        chk("sb_req_cycles", n_req, 3);

        run(mk(7, LB3), LTYPE, 32'h2002, 0, 32'h0080_0000, 0, 1);
        chk("lb_wdata", last_rfwd, 32'hFFFF_FF80); chk("lb_waddr", last_waddr, 7);
        chk("lb_rf_count", n_rf, 1);
        run(mk(7, LBU3), LTYPE, 32'h2002, 0, 32'h0080_0000, 1, 0);
        chk("lbu_wdata", last_rfwd, 32'h0000_0080);
        run(mk(9, LH3), LTYPE, 32'h2002, 0, 32'h8001_0000, 3, 0);
        chk("lh_wdata", last_rfwd, 32'hFFFF_8001);
        run(mk(9, LHU3), LTYPE, 32'h2000, 0, 32'h1234_F00D, 0, 0);
        chk("lhu_wdata", last_rfwd, 32'h0000_F00D);
        run(mk(10, LW3), LTYPE, 32'h2004, 0, 32'hCAFE_BABE, 4, 0);
        chk("lw_wdata", last_rfwd, 32'hCAFE_BABE);

        run(mk(0, SH3), STYPE, 32'h2002, 32'h1234_BEEF, 0, 1, 0);
        chk("sh_strb", last_strb, 4'b1100); chk("sh_wdata", last_wdata, 32'hBEEF_BEEF);
        run(mk(0, SW3), STYPE, 32'h2004, 32'h1122_3344, 0, 0, 0);
        chk("sw_strb", last_strb, 4'b1111);

        run(mk(12, 0), ITYPE, 32'hFFFF_FFF0, 0, 0, -1, 0);
        run(32'hABCD_E1B7, UTYPE, 32'h0, 0, 0, -1, 0);
        chk("lui_wdata", last_rfwd, 32'hABCD_E000); chk("lui_waddr", last_waddr, 3);
        run(32'h1234_5037, UTYPE, 32'h0, 0, 0, -1, 0);
        chk("rd0_rf_count", n_rf, 0);

        run(mk(4, 0), BTYPE, 32'h10, 0, 0, -1, 0);
        chk("btype_rf_count", n_rf, 0); chk("btype_req_count", n_req, 0);
        run(mk(4, 0), 5'd0, 32'h10, 0, 0, -1, 0);
        chk("unk_itype_req", n_req, 0);
        run(mk(4, 3), LTYPE, 32'h10, 0, 0, 0, 0);
        chk("unk_ld_f3_req", n_req, 0); chk("unk_ld_f3_rf", n_rf, 0);
        run(mk(0, 4), STYPE, 32'h10, 0, 0, 0, 0);
        chk("unk_st_f3_req", n_req, 0);

        run(mk(8, LW3), LTYPE, 32'h3002, 0, 0, 0, 0);
        chk("misal_fault", fault_o, 1); chk("misal_req", n_req, 0);
        chk("misal_rf", n_rf, 0); chk("misal_busy_after", busy_o, 0);
        run(mk(8, LH3), LTYPE, 32'h3001, 0, 0, 0, 0);

        run(mk(8, LW3), LTYPE, 32'h3000, 0, 32'h1, -1, 0);
        chk("timeout_req_cycles", n_req, 15); chk("timeout_rf", n_rf, 0);
        chk("timeout_fault", fault_o, 1);

        chk_en = 0;
        @(posedge clk); #1;
        stage_i = 3'd4; ir_i = mk(6, LW3); itype_i = LTYPE; y_i = 32'h4000;
        @(posedge clk); #1; stage_i = 3'd0;
        @(posedge clk); #1;
        chk("req_before_reset", mem_req_o, 1);
        reset = 0; #1;
        chk("req_async_reset", mem_req_o, 0);
        chk("busy_async_reset", busy_o, 0);
        chk("fault_async_reset", fault_o, 0);
        chk("addr_async_reset", mem_addr_o, 0);
        @(negedge clk); reset = 1;
        n_rf = 0; n_req = 0;
        e_fault = 0; set_idle(); chk_en = 1;
        @(posedge clk); #1; mem_ack_i = 1; mem_rdata_i = 32'hFFFF_FFFF;
        @(posedge clk); #1; mem_ack_i = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("late_ack_rf", n_rf, 0); chk("late_ack_req", n_req, 0);
        chk_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
